mux421_sync_checker: RTL and testbench

- Clocked self-checking monitor that sits directly downstream of the 4-to-1 mux DUV in the mux421 benches.
- Samples the mux inputs, selects and DUV output on a strobe, and computes the reference result.
- Aligns the reference result to a configurable DUV latency, compares, and counts checks and mismatches.
- Captures the first failing vector and raises Done/Pass once the expected vector count has been checked.

---
 rtl/mux421_pkg.sv | 30 +++
 rtl/mux421_align_pipe.sv | 37 +++
 rtl/mux421_sync_checker.sv | 123 ++++++++++++
 tb/tb_mux421_sync_checker.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux421_pkg.sv
// Shared types and reference model for the mux421 checkers.
// FSM encoding, vector width and the expected-output function.
package mux421_pkg;

  localparam int VEC_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic             valid;
    logic             exp;
    logic [VEC_W-1:0] vec;
  } smp_t;

  // vec = {Sel1,Sel0,In3,In2,In1,In0}
  function automatic logic mux421_ref(
    input logic [VEC_W-1:0] vec
  );
    logic [3:0] d;
    logic [1:0] s;
    d = vec[3:0];
    s = vec[5:4];
    return d[s];
  endfunction

endpackage

// File: rtl/mux421_align_pipe.sv
// LATENCY-deep register chain carrying {valid, exp, vec}.
// Degenerates to a wire when LATENCY is 0.
module mux421_align_pipe
  import mux421_pkg::*;
#(
  parameter int LATENCY = 0
) (
  input  logic Clock,
  input  logic nReset,
  input  smp_t d_i,
  output smp_t q_o
);

  generate
    if (LATENCY == 0) begin : g_wire
      logic unused_clk;
      assign unused_clk = Clock ^ nReset;
      assign q_o = d_i;
    end else begin : g_pipe
      smp_t pipe_q [LATENCY];

      always_ff @(posedge Clock) begin
        if (!nReset) begin
          for (int i = 0; i < LATENCY; i++)
            pipe_q[i] <= '0;
        end else begin
          pipe_q[0] <= d_i;
          for (int i = 1; i < LATENCY; i++)
            pipe_q[i] <= pipe_q[i-1];
        end
      end

      assign q_o = pipe_q[LATENCY-1];
    end
  endgenerate

endmodule

// File: rtl/mux421_sync_checker.sv
// Clocked self-checking monitor for the 4-to-1 mux DUV.
// Optional coverage bitmap: MUX421_CHECK_COVERAGE_EN.
module mux421_sync_checker
  import mux421_pkg::*;
#(
  parameter int LATENCY     = 0,
  parameter int NUM_VECTORS = 64,
  parameter int CNT_W       = 8
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             Valid,
  input  logic             In0,
  input  logic             In1,
  input  logic             In2,
  input  logic             In3,
  input  logic             Sel0,
  input  logic             Sel1,
  input  logic             Out,
  output logic             Done,
  output logic             Pass,
  output logic [CNT_W-1:0] ErrCount,
  output logic [CNT_W-1:0] CheckCount,
  output logic [VEC_W-1:0] FirstErrVec,
  output logic             FirstErrValid
`ifdef MUX421_CHECK_COVERAGE_EN
  ,
  output logic             CovFull,
  output logic [6:0]       CovCount
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_NUM =
    CNT_W'(NUM_VECTORS);

  logic [VEC_W-1:0] vec;
  smp_t             s_in;
  smp_t             s_dly;

  assign vec = {Sel1, Sel0, In3, In2, In1, In0};
  assign s_in.valid = Valid;
  assign s_in.exp   = mux421_ref(vec);
  assign s_in.vec   = vec;

  mux421_align_pipe #(
    .LATENCY(LATENCY)
  ) u_pipe (
    .Clock (Clock),
    .nReset(nReset),
    .d_i   (s_in),
    .q_o   (s_dly)
  );

  state_e           state_q;
  logic [CNT_W-1:0] chk_q, chk_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [VEC_W-1:0] fev_q;
  logic             fevv_q;
  logic             done_q;
  logic             pass_q;
  logic             cmp;
  logic             miss;

  assign cmp   = s_dly.valid && (state_q != DONE);
  // case inequality: X/Z on Out is a mismatch
  assign miss  = cmp && (Out !== s_dly.exp);
  assign chk_d = chk_q + CNT_W'(1);
  assign err_d = (err_q == CNT_MAX) ? err_q
                                     : err_q + CNT_W'(1);

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      state_q <= IDLE;
      chk_q   <= '0;
      err_q   <= '0;
      fev_q   <= '0;
      fevv_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      done_q <= (state_q == DONE);
      pass_q <= (state_q == DONE) && (err_q == '0);
      unique case (state_q)
        IDLE:    if (Valid) state_q <= RUN;
        RUN:     state_q <= RUN;
        DONE:    state_q <= DONE;
        default: state_q <= IDLE;
      endcase
      if (cmp) begin
        chk_q <= chk_d;
        if (chk_d == CNT_NUM) state_q <= DONE;
      end
      if (miss) begin
        err_q <= err_d;
        if (!fevv_q) begin
          fev_q  <= s_dly.vec;
          fevv_q <= 1'b1;
        end
      end
    end
  end

  assign Done          = done_q;
  assign Pass          = pass_q;
  assign ErrCount      = err_q;
  assign CheckCount    = chk_q;
  assign FirstErrVec   = fev_q;
  assign FirstErrValid = fevv_q;

`ifdef MUX421_CHECK_COVERAGE_EN
  logic [63:0] cov_q;

  always_ff @(posedge Clock) begin
    if (!nReset) cov_q <= '0;
    else if (cmp) cov_q[s_dly.vec] <= 1'b1;
  end

  assign CovFull  = &cov_q;
  assign CovCount = 7'($countones(cov_q));
`endif

endmodule

// File: tb/tb_mux421_sync_checker.sv
// Bench for mux421_sync_checker: six checker instances fed by
// ideal, delayed, inverted and stuck DUVs against a history model.
module tb_mux421_sync_checker;
  import mux421_pkg::*;

  localparam int NI = 6;
  localparam int LAT [NI] = '{0, 2, 1, 0, 0, 0};
  localparam int NV  [NI] = '{64, 64, 64, 7, 64, 63};
  localparam int CW  [NI] = '{8, 8, 8, 3, 8, 8};

  logic Clock = 1'b0;
  logic nReset = 1'b0;
  logic Valid = 1'b0;
  logic In0 = 1'b0, In1 = 1'b0, In2 = 1'b0, In3 = 1'b0;
  logic Sel0 = 1'b0, Sel1 = 1'b0;

  always #5 Clock = ~Clock;

  logic [5:0] vec_w;
  logic       ideal;
  logic       r1 = 1'b0, r2 = 1'b0;
  assign vec_w = {Sel1, Sel0, In3, In2, In1, In0};
  assign ideal = vec_w[vec_w[5:4]];
  always @(posedge Clock) begin
    r1 <= ideal;
    r2 <= r1;
  end

  logic [NI-1:0] outs;
  assign outs = {ideal, 1'b0, ~ideal, r2, r2, ideal};

  logic [NI-1:0] done, pass, fev_v;
  logic [7:0]    ec  [NI];
  logic [7:0]    cc  [NI];
  logic [5:0]    fev [NI];
`ifdef MUX421_CHECK_COVERAGE_EN
  logic [NI-1:0] cfull;
  logic [6:0]    ccnt [NI];
`endif

  generate
    for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int W = CW[g];
      logic [W-1:0] e_w, c_w;
      mux421_sync_checker #(
        .LATENCY    (LAT[g]),
        .NUM_VECTORS(NV[g]),
        .CNT_W      (W)
      ) u_dut (
        .Clock        (Clock),
        .nReset       (nReset),
        .Valid        (Valid),
        .In0          (In0),
        .In1          (In1),
        .In2          (In2),
        .In3          (In3),
        .Sel0         (Sel0),
        .Sel1         (Sel1),
        .Out          (outs[g]),
        .Done         (done[g]),
        .Pass         (pass[g]),
        .ErrCount     (e_w),
        .CheckCount   (c_w),
        .FirstErrVec  (fev[g]),
        .FirstErrValid(fev_v[g])
`ifdef MUX421_CHECK_COVERAGE_EN
        ,
        .CovFull      (cfull[g]),
        .CovCount     (ccnt[g])
`endif
      );
      assign ec[g] = 8'(e_w);
      assign cc[g] = 8'(c_w);
    end
  endgenerate

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Model: per-edge history of applied vectors; instance i compares
  // the vector applied LAT[i] edges earlier unless a reset intervened.
  int          m_chk  [NI];
  int          m_err  [NI];
  logic [5:0]  m_fev  [NI];
  bit          m_fevv [NI];
  bit          m_md   [NI];
  bit          m_done [NI];
  bit          m_pass [NI];
  logic [63:0] m_cov  [NI];
  bit          vh [1024];
  logic [5:0]  vv [1024];
  int          ecnt = 0;
  int          last_rst = -1;
  bit          chk_en = 1'b0;

  always @(negedge Clock) begin
    int         src;
    logic [5:0] v;
    logic       e;
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("done%0d", i), done[i], m_done[i]);
        chk($sformatf("pass%0d", i), pass[i], m_pass[i]);
        chk($sformatf("errcnt%0d", i), ec[i], m_err[i]);
        chk($sformatf("chkcnt%0d", i), cc[i], m_chk[i]);
        chk($sformatf("fevv%0d", i), fev_v[i], m_fevv[i]);
        chk($sformatf("fev%0d", i), fev[i], m_fev[i]);
`ifdef MUX421_CHECK_COVERAGE_EN
        chk($sformatf("covcnt%0d", i), ccnt[i],
            $countones(m_cov[i]));
        chk($sformatf("covfull%0d", i), cfull[i],
            m_cov[i] == '1);
`endif
      end
      vh[ecnt] = Valid;
      vv[ecnt] = vec_w;
      if (!nReset) begin
        last_rst = ecnt;
        for (int i = 0; i < NI; i++) begin
          m_chk[i] = 0;  m_err[i] = 0;
          m_fev[i] = '0; m_fevv[i] = 0;
          m_md[i] = 0;   m_done[i] = 0;
          m_pass[i] = 0; m_cov[i] = '0;
        end
      end else begin
        for (int i = 0; i < NI; i++) begin
          m_done[i] = m_md[i];
          m_pass[i] = m_md[i] && (m_err[i] == 0);
          src = ecnt - LAT[i];
          if (src > last_rst && !m_md[i]) begin
            if (vh[src]) begin
              v = vv[src];
              e = v[v[5:4]];
              m_chk[i]++;
              m_cov[i][v] = 1'b1;
              if (outs[i] !== e) begin
                if (m_err[i] < (1 << CW[i]) - 1) m_err[i]++;
                if (!m_fevv[i]) begin
                  m_fevv[i] = 1'b1;
                  m_fev[i] = v;
                end
              end
              if (m_chk[i] == NV[i]) m_md[i] = 1'b1;
            end
          end
        end
      end
      ecnt++;
    end
  end

  task automatic drive(input logic v, input logic [5:0] x);
    {Sel1, Sel0, In3, In2, In1, In0} = x;
    Valid = v;
    @(posedge Clock);
    #1;
  endtask

  initial begin
    nReset = 1'b0;
    @(posedge Clock);
    #1;
    chk_en = 1'b1;
    drive(0, 6'd0);
    chk("rst_done", done[0], 0);
    chk("rst_chk", cc[0], 0);
    chk("rst_err", ec[0], 0);
    chk("rst_fevv", fev_v[0], 0);
    nReset = 1'b1;

    for (int k = 0; k < 64; k++) drive(1, 6'(k));
    chk("l0_chk64", cc[0], 64);
    chk("l0_done_late", done[0], 0);
    drive(0, 6'd0);
    chk("l0_done", done[0], 1);
    chk("l0_pass", pass[0], 1);
    for (int k = 0; k < 3; k++) drive(0, 6'd0);
    chk("l0_fevv", fev_v[0], 0);
    chk("l2_err", ec[1], 0);
    chk("l2_pass", pass[1], 1);
    chk("l1_err_nz", ec[2] != 0, 1);
    chk("sat_err", ec[3], 7);
    chk("sat_done", done[3], 1);
    chk("sat_pass", pass[3], 0);
    chk("stuck_err", ec[4], 32);
    chk("stuck_fev", fev[4], 6'b000001);
`ifdef MUX421_CHECK_COVERAGE_EN
    chk("cov64_cnt", ccnt[0], 64);
    chk("cov64_full", cfull[0], 1);
    chk("cov63_cnt", ccnt[5], 63);
    chk("cov63_full", cfull[5], 0);
`endif

    nReset = 1'b0;
    drive(0, 6'd0);
    nReset = 1'b1;
    drive(1, 6'b010100);
    chk("fault_first_ok", ec[4], 0);
    chk("fault_chk1", cc[4], 1);
    drive(1, 6'b000001);
    chk("fault_err1", ec[4], 1);
    chk("fault_fev", fev[4], 6'b000001);
    chk("fault_fevv", fev_v[4], 1);

    nReset = 1'b0;
    drive(0, 6'd0);
    nReset = 1'b1;
    for (int k = 0; k < 12; k++) drive(1, 6'((k * 5 + 3) % 64));
    chk("mid_chk10", cc[1], 10);
    nReset = 1'b0;
    drive(0, 6'd0);
    chk("mid_rst_chk", cc[1], 0);
    chk("mid_rst_err", ec[1], 0);
    chk("mid_rst_done", done[1], 0);
    nReset = 1'b1;
    drive(0, 6'd0);
    drive(0, 6'd0);
    chk("mid_no_stale", cc[1], 0);
    drive(0, 6'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
